// File: rtl/wb_stage_ex.sv
// Write-back stage of the five-stage MIPS core: commits byte-strobed register writes,
// publishes the forwarding bus and holds the minimal CP0 exception state.
module wb_stage_ex #(
    parameter int          DATA_W    = 32,
    parameter int          REG_AW    = 5,
    parameter int          STRB_W    = DATA_W / 8,
    parameter logic [31:0] EX_ENTRY  = 32'hBFC00380,
    parameter int          MS_BUS_WD = 8 + STRB_W + REG_AW + DATA_W + 32
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 ws_allowin,
    input  logic                 ms_to_ws_valid,
    input  logic [MS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [STRB_W-1:0]    rf_we,
    output logic [REG_AW-1:0]    rf_waddr,
    output logic [DATA_W-1:0]    rf_wdata,
    output logic                 fwd_valid,
    output logic [REG_AW-1:0]    fwd_dest,
    output logic [DATA_W-1:0]    fwd_data,
    output logic                 ws_flush,
    output logic [31:0]          ws_flush_pc,
    output logic [31:0]          cp0_epc,
    output logic                 cp0_exl,
    output logic [31:0]          cp0_cause,
    output logic [31:0]          debug_wb_pc,
    output logic [3:0]           debug_wb_rf_wen,
    output logic [4:0]           debug_wb_rf_wnum,
    output logic [31:0]          debug_wb_rf_wdata
);

    localparam int RES_LSB  = 32;
    localparam int DEST_LSB = RES_LSB + DATA_W;
    localparam int STRB_LSB = DEST_LSB + REG_AW;
    localparam int BD_BIT   = STRB_LSB + STRB_W;
    localparam int ERET_BIT = BD_BIT + 1;
    localparam int CODE_LSB = ERET_BIT + 1;
    localparam int EX_BIT   = CODE_LSB + 5;

    logic                 ws_valid;
    logic                 ws_ready_go;
    logic [MS_BUS_WD-1:0] ws_bus;

    logic [31:0]          ws_pc;
    logic [DATA_W-1:0]    ws_result;
    logic [REG_AW-1:0]    ws_dest;
    logic [STRB_W-1:0]    ws_we_strb;
    logic                 ws_bd;
    logic                 ws_eret;
    logic [4:0]           ws_excode;
    logic                 ws_ex;

    logic                 ex_commit;
    logic                 eret_commit;
    logic                 cause_bd;
    logic [4:0]           cause_excode;

    assign ws_pc      = ws_bus[31:0];
    assign ws_result  = ws_bus[RES_LSB +: DATA_W];
    assign ws_dest    = ws_bus[DEST_LSB +: REG_AW];
    assign ws_we_strb = ws_bus[STRB_LSB +: STRB_W];
    assign ws_bd      = ws_bus[BD_BIT];
    assign ws_eret    = ws_bus[ERET_BIT];
    assign ws_excode  = ws_bus[CODE_LSB +: 5];
    assign ws_ex      = ws_bus[EX_BIT];

    assign ws_ready_go = 1'b1;
    assign ws_allowin  = !ws_valid || ws_ready_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid <= 1'b0;
        end else if (ws_flush) begin
            ws_valid <= 1'b0;
        end else if (ws_allowin) begin
            ws_valid <= ms_to_ws_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ws_bus <= '0;
        end else if (ms_to_ws_valid && ws_allowin && !ws_flush) begin
            ws_bus <= ms_to_ws_bus;
        end
    end

    // ex wins over eret when both are set
    assign ex_commit   = ws_valid && ws_ex;
    assign eret_commit = ws_valid && !ws_ex && ws_eret;

    always_comb begin
        rf_we       = '0;
        rf_waddr    = '0;
        ws_flush    = 1'b0;
        ws_flush_pc = 32'h0;
        if (ws_valid) begin
            rf_waddr = ws_dest;
            if (ex_commit) begin
                ws_flush    = 1'b1;
                ws_flush_pc = EX_ENTRY;
            end else if (eret_commit) begin
                ws_flush    = 1'b1;
                ws_flush_pc = cp0_epc;
            end else begin
                rf_we = ws_we_strb;
            end
        end
    end

    assign rf_wdata  = ws_result;
    assign fwd_valid = ws_valid && (|rf_we) && (ws_dest != '0);
    assign fwd_dest  = fwd_valid ? ws_dest : '0;
    assign fwd_data  = ws_result;

    // A nested exception (EXL already set) keeps the original EPC and BD.
    always_ff @(posedge clk) begin
        if (reset) begin
            cp0_epc      <= 32'h0;
            cp0_exl      <= 1'b0;
            cause_bd     <= 1'b0;
            cause_excode <= 5'd0;
        end else if (ex_commit) begin
            if (!cp0_exl) begin
                cp0_epc  <= ws_bd ? (ws_pc - 32'd4) : ws_pc;
                cause_bd <= ws_bd;
            end
            cause_excode <= ws_excode;
            cp0_exl      <= 1'b1;
        end else if (eret_commit) begin
            cp0_exl <= 1'b0;
        end
    end

    assign cp0_cause = {cause_bd, 24'b0, cause_excode, 2'b0};

    assign debug_wb_pc = ws_pc;

    generate
        if (STRB_W >= 4) begin : g_wen_trunc
            assign debug_wb_rf_wen = rf_we[3:0];
        end else begin : g_wen_ext
            assign debug_wb_rf_wen = {{(4 - STRB_W){1'b0}}, rf_we};
        end

        if (REG_AW >= 5) begin : g_wnum_trunc
            assign debug_wb_rf_wnum = ws_dest[4:0];
        end else begin : g_wnum_ext
            assign debug_wb_rf_wnum = {{(5 - REG_AW){1'b0}}, ws_dest};
        end

        if (DATA_W >= 32) begin : g_wdata_trunc
            assign debug_wb_rf_wdata = ws_result[31:0];
        end else begin : g_wdata_ext
            assign debug_wb_rf_wdata = {{(32 - DATA_W){1'b0}}, ws_result};
        end
    endgenerate

endmodule

// File: tb/tb_wb_stage_ex.sv
// Bench for wb_stage_ex: a table of beats with their expected commit-cycle outputs
// goes through a scoreboard queue, followed by a hand-written reset-during-commit sequence.
module tb_wb_stage_ex;

    localparam int BUS_WD = 81;

    logic              clk;
    logic              reset;
    logic              ws_allowin;
    logic              ms_to_ws_valid;
    logic [BUS_WD-1:0] ms_to_ws_bus;
    logic [3:0]        rf_we;
    logic [4:0]        rf_waddr;
    logic [31:0]       rf_wdata;
    logic              fwd_valid;
    logic [4:0]        fwd_dest;
    logic [31:0]       fwd_data;
    logic              ws_flush;
    logic [31:0]       ws_flush_pc;
    logic [31:0]       cp0_epc;
    logic              cp0_exl;
    logic [31:0]       cp0_cause;
    logic [31:0]       debug_wb_pc;
    logic [3:0]        debug_wb_rf_wen;
    logic [4:0]        debug_wb_rf_wnum;
    logic [31:0]       debug_wb_rf_wdata;

    wb_stage_ex dut (
        .clk               (clk),
        .reset             (reset),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .fwd_valid         (fwd_valid),
        .fwd_dest          (fwd_dest),
        .fwd_data          (fwd_data),
        .ws_flush          (ws_flush),
        .ws_flush_pc       (ws_flush_pc),
        .cp0_epc           (cp0_epc),
        .cp0_exl           (cp0_exl),
        .cp0_cause         (cp0_cause),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        ex;
        logic [4:0]  excode;
        logic        eret;
        logic        bd;
        logic [3:0]  strb;
        logic [4:0]  dest;
        logic [31:0] res;
        logic [31:0] pc;
        logic [3:0]  e_we;
        logic        e_fv;
        logic [4:0]  e_fd;
        logic        e_fl;
        logic [31:0] e_fpc;
        logic [31:0] e_epc;
        logic        e_exl;
        logic [31:0] e_cause;
        logic        chk_data;   // normal commit: check address, data and trace
        logic        e_inv;      // stage expected empty: address must read 0
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];
    vec_t exp_q[$];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic drive(input vec_t r);
        ms_to_ws_valid = r.v;
        ms_to_ws_bus   = {r.ex, r.excode, r.eret, r.bd, r.strb, r.dest, r.res, r.pc};
    endtask

    task automatic drive_idle();
        ms_to_ws_valid = 1'b0;
        ms_to_ws_bus   = '0;
    endtask

    initial begin
        vec_t r;
        //                v     ex    code   eret  bd    strb   dest    result        pc             we    fv    fd     fl    flush_pc       epc            exl   cause          data  inv
        vecs[0]  = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 4'hF, 5'd8,  32'h12345678, 32'hBFC00000, 4'hF, 1'b1, 5'd8,  1'b0, 32'h0,         32'h0,         1'b0, 32'h0,         1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 4'h3, 5'd0,  32'hA5A50F0F, 32'hBFC00004, 4'h3, 1'b0, 5'd0,  1'b0, 32'h0,         32'h0,         1'b0, 32'h0,         1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 5'd8,  1'b0, 1'b0, 4'hF, 5'd9,  32'h11111111, 32'hBFC00100, 4'h0, 1'b0, 5'd0,  1'b1, 32'hBFC00380, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 4'hF, 5'd10, 32'h22222222, 32'hBFC00008, 4'h0, 1'b0, 5'd0,  1'b0, 32'h0,         32'hBFC00100, 1'b1, 32'h00000020, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 4'h0, 5'd0,  32'h0,        32'h0,        4'h0, 1'b0, 5'd0,  1'b0, 32'h0,         32'hBFC00100, 1'b1, 32'h00000020, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 4'h0, 5'd0,  32'h0,        32'hBFC00300, 4'h0, 1'b0, 5'd0,  1'b1, 32'hBFC00100, 32'hBFC00100, 1'b1, 32'h00000020, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 4'h0, 5'd0,  32'h0,        32'h0,        4'h0, 1'b0, 5'd0,  1'b0, 32'h0,         32'hBFC00100, 1'b0, 32'h00000020, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 5'd4,  1'b0, 1'b1, 4'hF, 5'd3,  32'h0,        32'hBFC00204, 4'h0, 1'b0, 5'd0,  1'b1, 32'hBFC00380, 32'hBFC00100, 1'b0, 32'h00000020, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 4'h0, 5'd0,  32'h0,        32'h0,        4'h0, 1'b0, 5'd0,  1'b0, 32'h0,         32'hBFC00200, 1'b1, 32'h80000010, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 5'd10, 1'b0, 1'b0, 4'hF, 5'd4,  32'h0,        32'hBFC00400, 4'h0, 1'b0, 5'd0,  1'b1, 32'hBFC00380, 32'hBFC00200, 1'b1, 32'h80000010, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 4'h0, 5'd0,  32'h0,        32'h0,        4'h0, 1'b0, 5'd0,  1'b0, 32'h0,         32'hBFC00200, 1'b1, 32'h80000028, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 4'h0, 5'd0,  32'h0,        32'hBFC00600, 4'h0, 1'b0, 5'd0,  1'b1, 32'hBFC00200, 32'hBFC00200, 1'b1, 32'h80000028, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 4'h0, 5'd0,  32'h0,        32'h0,        4'h0, 1'b0, 5'd0,  1'b0, 32'h0,         32'hBFC00200, 1'b0, 32'h80000028, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 4'hC, 5'd31, 32'hDEADBEEF, 32'hBFC00208, 4'hC, 1'b1, 5'd31, 1'b0, 32'h0,         32'hBFC00200, 1'b0, 32'h80000028, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 4'h0, 5'd2,  32'h00000001, 32'hBFC0020C, 4'h0, 1'b0, 5'd0,  1'b0, 32'h0,         32'hBFC00200, 1'b0, 32'h80000028, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 4'hF, 5'd5,  32'h0,        32'hBFC00500, 4'h0, 1'b0, 5'd0,  1'b1, 32'hBFC00380, 32'hBFC00200, 1'b0, 32'h80000028, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 4'h0, 5'd0,  32'h0,        32'h0,        4'h0, 1'b0, 5'd0,  1'b0, 32'h0,         32'hBFC00500, 1'b1, 32'h00000030, 1'b0, 1'b1};
        vecs[17] = '{1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 4'h0, 5'd0,  32'h0,        32'hBFC00700, 4'h0, 1'b0, 5'd0,  1'b1, 32'hBFC00500, 32'hBFC00500, 1'b1, 32'h00000030, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 4'h0, 5'd0,  32'h0,        32'h0,        4'h0, 1'b0, 5'd0,  1'b0, 32'h0,         32'hBFC00500, 1'b0, 32'h00000030, 1'b0, 1'b1};
        vecs[19] = '{1'b1, 1'b1, 5'd1,  1'b0, 1'b1, 4'hF, 5'd6,  32'h0,        32'h00000000, 4'h0, 1'b0, 5'd0,  1'b1, 32'hBFC00380, 32'hBFC00500, 1'b0, 32'h00000030, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 4'h0, 5'd0,  32'h0,        32'h0,        4'h0, 1'b0, 5'd0,  1'b0, 32'h0,         32'hFFFFFFFC, 1'b1, 32'h80000004, 1'b0, 1'b1};

        reset = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_allowin", 32'(ws_allowin), 32'd1);
        chk("rst_we",      32'(rf_we),      32'd0);
        chk("rst_flush",   32'(ws_flush),   32'd0);
        chk("rst_fv",      32'(fwd_valid),  32'd0);
        chk("rst_fd",      32'(fwd_dest),   32'd0);
        chk("rst_epc",     cp0_epc,         32'd0);
        chk("rst_exl",     32'(cp0_exl),    32'd0);
        chk("rst_cause",   cp0_cause,       32'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            r = exp_q.pop_front();
            chk($sformatf("r%0d_allowin", i), 32'(ws_allowin), 32'd1);
            chk($sformatf("r%0d_we", i),      32'(rf_we),      32'(r.e_we));
            chk($sformatf("r%0d_fv", i),      32'(fwd_valid),  32'(r.e_fv));
            chk($sformatf("r%0d_fd", i),      32'(fwd_dest),   32'(r.e_fd));
            chk($sformatf("r%0d_flush", i),   32'(ws_flush),   32'(r.e_fl));
            chk($sformatf("r%0d_fpc", i),     ws_flush_pc,     r.e_fpc);
            chk($sformatf("r%0d_epc", i),     cp0_epc,         r.e_epc);
            chk($sformatf("r%0d_exl", i),     32'(cp0_exl),    32'(r.e_exl));
            chk($sformatf("r%0d_cause", i),   cp0_cause,       r.e_cause);
            if (r.e_inv) chk($sformatf("r%0d_waddr0", i), 32'(rf_waddr), 32'd0);
            if (r.chk_data) begin
                chk($sformatf("r%0d_waddr", i), 32'(rf_waddr),         32'(r.dest));
                chk($sformatf("r%0d_wdata", i), rf_wdata,              r.res);
                chk($sformatf("r%0d_fdata", i), fwd_data,              r.res);
                chk($sformatf("r%0d_dpc", i),   debug_wb_pc,           r.pc);
                chk($sformatf("r%0d_dwen", i),  32'(debug_wb_rf_wen),  32'(r.e_we));
                chk($sformatf("r%0d_dnum", i),  32'(debug_wb_rf_wnum), 32'(r.dest));
                chk($sformatf("r%0d_ddat", i),  debug_wb_rf_wdata,     r.res);
            end
        end
        drive_idle();

        // Reset arriving during an exception commit must override the CP0 update.
        ms_to_ws_valid = 1'b1;
        ms_to_ws_bus   = {1'b1, 5'd8, 1'b0, 1'b0, 4'hF, 5'd7, 32'h0, 32'hBFC00800};
        @(posedge clk);
        #1;
        chk("rc_flush_pre", 32'(ws_flush), 32'd1);
        reset          = 1'b1;
        ms_to_ws_bus   = {1'b0, 5'd0, 1'b0, 1'b0, 4'hF, 5'd7, 32'h55AA55AA, 32'hBFC00900};
        @(posedge clk);
        #1;
        chk("rc_epc",   cp0_epc,          32'd0);
        chk("rc_exl",   32'(cp0_exl),     32'd0);
        chk("rc_cause", cp0_cause,        32'd0);
        chk("rc_flush", 32'(ws_flush),    32'd0);
        chk("rc_we",    32'(rf_we),       32'd0);
        chk("rc_fv",    32'(fwd_valid),   32'd0);
        reset = 1'b0;
        drive_idle();
        @(posedge clk);
        #1;
        chk("rc_idle_we", 32'(rf_we), 32'd0);

        // Stage resumes normally after the reset.
        ms_to_ws_valid = 1'b1;
        ms_to_ws_bus   = {1'b0, 5'd0, 1'b0, 1'b0, 4'h1, 5'd7, 32'h000000AB, 32'hBFC00A00};
        @(posedge clk);
        #1;
        drive_idle();
        chk("post_we",  32'(rf_we),    32'd1);
        chk("post_fd",  32'(fwd_dest), 32'd7);
        chk("post_fpc", ws_flush_pc,   32'd0);
        @(posedge clk);
        #1;
        chk("post_idle_fv", 32'(fwd_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
